// File: rtl/ncl_word_reader.sv
// rtl/ncl_word_reader.sv - clocked dual-rail NCL word receiver with valid/ready output and completion drive
module ncl_word_reader #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             init,
  input  logic [WIDTH-1:0] rail0,
  input  logic [WIDTH-1:0] rail1,
  output logic             rd_comp,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [WIDTH-1:0] word_data,
  output logic [15:0]      word_cnt,
  output logic             rail_err
);

  typedef enum logic [1:0] {
    WAIT_DATA,
    HOLD,
    WAIT_NULL
  } state_t;

  state_t state, state_n;

  // Stage 0 is the first flop fed by the asynchronous rails; the top stage is the only one used.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync0, sync1;
  logic [WIDTH-1:0] s0, s1;
  logic all_data, all_null, illegal;

  logic             valid_n, comp_n, err_n;
  logic [WIDTH-1:0] data_n;
  logic [15:0]      cnt_n;

  assign s0 = sync0[SYNC_STAGES-1];
  assign s1 = sync1[SYNC_STAGES-1];

  // A bit is DATA when exactly one rail is high, NULL when neither is, ILLEGAL when both are.
  assign all_data = &(s0 ^ s1);
  assign all_null = ~|(s0 | s1);
  assign illegal  = |(s0 & s1);

  // Per-rail synchronizer chains, cleared to NULL on init.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        sync0[i] <= sync0[i-1];
        sync1[i] <= sync1[i-1];
      end
      sync0[0] <= rail0;
      sync1[0] <= rail1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state      <= WAIT_DATA;
      rd_comp    <= 1'b0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_cnt   <= '0;
      rail_err   <= 1'b0;
    end else begin
      state      <= state_n;
      rd_comp    <= comp_n;
      word_valid <= valid_n;
      word_data  <= data_n;
      word_cnt   <= cnt_n;
      rail_err   <= err_n;
    end
  end

  // Next state and next output values; the first complete DATA sample is final under NCL monotonicity.
  always_comb begin
    state_n = state;
    comp_n  = rd_comp;
    valid_n = word_valid;
    data_n  = word_data;
    cnt_n   = word_cnt;
    err_n   = rail_err | illegal;
    case (state)
      WAIT_DATA: begin
        if (all_data) begin
          data_n  = s1;
          valid_n = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (word_valid && word_ready) begin
          valid_n = 1'b0;
          comp_n  = 1'b1;
          cnt_n   = word_cnt + 16'd1;
          state_n = WAIT_NULL;
        end
      end
      WAIT_NULL: begin
        if (all_null) begin
          comp_n  = 1'b0;
          state_n = WAIT_DATA;
        end
      end
      default: state_n = WAIT_DATA;
    endcase
  end

endmodule

// File: tb/tb_ncl_word_reader.sv
// tb/tb_ncl_word_reader.sv - self-checking bench for ncl_word_reader
module tb_ncl_word_reader;
  localparam int W  = 32;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          init;
  logic [W-1:0]  rail0, rail1;
  logic          rd_comp, word_valid, word_ready, rail_err;
  logic [W-1:0]  word_data;
  logic [15:0]   word_cnt;

  int            tests = 0;
  int            fails = 0;
  logic [15:0]   m_cnt;

  always #5 clk = ~clk;

  ncl_word_reader #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .init(init), .rail0(rail0), .rail1(rail1),
    .rd_comp(rd_comp), .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .word_cnt(word_cnt), .rail_err(rail_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Bits set in mask carry the dual-rail encoding of w; the rest are NULL.
  task automatic put(input logic [W-1:0] w, input logic [W-1:0] mask);
    rail1 = w & mask;
    rail0 = ~w & mask;
  endtask

  // One complete four-phase word transfer with expected timing derived from the sync depth.
  task automatic xfer(input logic [W-1:0] w, input int rdy_wait, input int part_cycles);
    logic [W-1:0] mask;
    int k;
    k = $urandom_range(0, W - 1);
    mask = $urandom;
    mask[k] = 1'b0;
    if (part_cycles > 0) begin
      put(w, mask);
      step(part_cycles);
      chk("partial_no_valid", word_valid, 0);
    end
    word_ready = (rdy_wait == 0);
    put(w, '1);
    step(SS);
    chk("valid_not_early", word_valid, 0);
    step(1);
    chk("valid_rise", word_valid, 1);
    chk("data", word_data, w);
    chk("comp_low_in_hold", rd_comp, 0);
    for (int i = 0; i < rdy_wait; i++) begin
      step(1);
      chk("hold_valid", word_valid, 1);
      chk("hold_data", word_data, w);
      chk("hold_comp", rd_comp, 0);
    end
    word_ready = 1'b1;
    step(1);
    m_cnt = m_cnt + 16'd1;
    chk("accept_valid", word_valid, 0);
    chk("accept_comp", rd_comp, 1);
    chk("accept_cnt", word_cnt, m_cnt);
    word_ready = 1'b0;
    if (part_cycles > 0) begin
      mask = $urandom;
      mask[k] = 1'b1;
      put(w, mask);
      step(part_cycles);
      chk("partial_null_comp", rd_comp, 1);
    end
    put(w, '0);
    step(SS);
    chk("null_not_early", rd_comp, 1);
    step(1);
    chk("null_comp_low", rd_comp, 0);
    chk("cnt_stable", word_cnt, m_cnt);
  endtask

  initial begin
    logic [W-1:0] w;
    init = 1'b1;
    word_ready = 1'b0;
    rail0 = '0;
    rail1 = '0;
    m_cnt = '0;
    #2;
    chk("rst_comp", rd_comp, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_data", word_data, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_err", rail_err, 0);
    @(negedge clk);
    init = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_valid", word_valid, 0);
      chk("idle_comp", rd_comp, 0);
    end
    chk("idle_cnt", word_cnt, 0);
    chk("idle_err", rail_err, 0);

    // Basic word with ready already high.
    xfer(32'hA5A5_0F0F, 0, 0);

    // Bit 31 arrives last, long after the rest.
    w = $urandom;
    w[31] = 1'b1;
    word_ready = 1'b1;
    put(w, 32'h7FFF_FFFF);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("bit31_missing_valid", word_valid, 0);
    end
    put(w, '1);
    step(SS + 1);
    chk("bit31_valid", word_valid, 1);
    chk("bit31_data31", word_data[31], 1);
    chk("bit31_data", word_data, w);
    step(1);
    m_cnt = m_cnt + 16'd1;
    chk("bit31_accept", rd_comp, 1);
    chk("bit31_cnt", word_cnt, m_cnt);
    word_ready = 1'b0;
    put(w, '0);
    step(SS + 1);
    chk("bit31_null", rd_comp, 0);

    // Consumer stalls for 7 cycles.
    xfer(32'h0000_0001, 7, 0);

    // Bit 5 ILLEGAL for 3 cycles, then legal.
    w = $urandom;
    put(w, '1);
    rail0[5] = 1'b1;
    rail1[5] = 1'b1;
    step(SS);
    chk("err_not_early", rail_err, 0);
    step(1);
    chk("err_set", rail_err, 1);
    chk("err_no_capture", word_valid, 0);
    w[5] = 1'b0;
    put(w, '1);
    step(SS);
    chk("err_still_no_capture", word_valid, 0);
    step(1);
    chk("err_sticky", rail_err, 1);
    chk("err_recover_valid", word_valid, 1);
    chk("err_recover_data", word_data, w);
    init = 1'b1;
    put(w, '0);
    #1;
    chk("init_err_clear", rail_err, 0);
    chk("init_valid_clear", word_valid, 0);
    chk("init_data_clear", word_data, 0);
    m_cnt = '0;
    @(negedge clk);
    init = 1'b0;
    step(SS + 1);
    chk("post_init_valid", word_valid, 0);
    chk("post_init_err", rail_err, 0);

    // Randomized transfers with skewed wavefronts and random consumer stalls.
    for (int n = 0; n < 12; n++) begin
      xfer($urandom, $urandom_range(0, 4), $urandom_range(0, 5));
    end

    // Counter wrap starting from 0xFFFE.
    force dut.word_cnt = 16'hFFFE;
    step(1);
    release dut.word_cnt;
    m_cnt = 16'hFFFE;
    step(1);
    chk("preload_cnt", word_cnt, 16'hFFFE);
    xfer($urandom, 0, 0);
    chk("cnt_ffff", word_cnt, 16'hFFFF);
    xfer($urandom, 1, 2);
    chk("cnt_wrap_0", word_cnt, 16'h0000);
    xfer($urandom, 0, 0);
    chk("cnt_after_wrap_1", word_cnt, 16'h0001);

    // init while holding a word.
    w = $urandom;
    word_ready = 1'b0;
    put(w, '1);
    step(SS + 1);
    chk("hold_before_init", word_valid, 1);
    init = 1'b1;
    #1;
    chk("init_hold_valid", word_valid, 0);
    chk("init_hold_cnt", word_cnt, 0);
    chk("init_hold_comp", rd_comp, 0);
    chk("init_hold_data", word_data, 0);
    @(negedge clk);
    init = 1'b0;
    put(w, '0);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
